// File: rtl/stream_pkg.sv
// Shared helpers for the stream width converters.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// idx_w(n)   : lane index width for n lanes, never less than 1 bit.
// onehot(m)  : true when exactly one bit of m is set (m zero-extended to MAX_LANES).
package stream_pkg;

  // Widest lane mask the helper functions accept; callers zero-extend into it.
  localparam int MAX_LANES = 64;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic onehot(input logic [MAX_LANES-1:0] mask);
    return (mask != '0) && ((mask & (mask - MAX_LANES'(1))) == '0);
  endfunction

endpackage

// File: rtl/stream_downsize_lsb_find.sv
// Lowest-set-bit priority encoder over an N-bit mask.
// Latency: purely combinational.
// Backpressure: none (no handshake).
//
// Ports:
//   mask [N-1:0]     input mask
//   idx  [IDX_W-1:0] index of the lowest set bit (0 when mask is empty)
//   any              mask has at least one bit set
module lsb_find
  import stream_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits the kept lanes of one wide beat, lowest lane first.
// Latency: first kept word is presented the cycle after the beat is accepted; one word per cycle.
// Backpressure: s_ready_o only opens when idle or when the final word of the held beat handshakes.
//
// Ports:
//   clk, rst_n                   clock; asynchronous active-high reset (1 = in reset)
//   s_data_i/keep_i/last_i       wide beat, per-lane keep mask and packet-end flag
//   s_valid_i / s_ready_o        wide-side handshake
//   m_data_o / m_last_o          narrow word and packet-end flag
//   m_valid_o / m_ready_i        narrow-side handshake
module stream_downsize
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 1,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_DATA_RATIO-1:0]                  s_keep_i,
  input  logic                                     s_last_i,
  input  logic                                     s_valid_i,
  output logic                                     s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                  m_data_o,
  output logic                                     m_last_o,
  output logic                                     m_valid_o,
  input  logic                                     m_ready_i
);

  localparam int IDX_W = idx_w(T_DATA_RATIO);

  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] beat_data;
  logic [T_DATA_RATIO-1:0]                   rem_keep;
  logic                                      beat_last;

  logic                    busy;
  logic [IDX_W-1:0]        sel;
  logic                    final_lane;
  logic [T_DATA_RATIO-1:0] clr_mask;
  logic                    s_hs;
  logic                    m_hs;

  lsb_find #(
    .N     (T_DATA_RATIO),
    .IDX_W (IDX_W)
  ) u_sel (
    .mask (rem_keep),
    .idx  (sel),
    .any  (busy)
  );

  // The word on the output is the last of the held beat.
  assign final_lane = onehot(MAX_LANES'(rem_keep));

  // Outputs are forced quiet while reset is held, independent of the registers.
  assign m_valid_o = busy & ~rst_n;
  assign m_data_o  = rst_n ? '0 : beat_data[sel];
  assign m_last_o  = ~rst_n & beat_last & final_lane;

  // Reloading on the final word's handshake keeps the output busy with no bubble.
  assign s_ready_o = ~rst_n & (~busy | (m_ready_i & final_lane));

  assign s_hs = s_valid_i & s_ready_o;
  assign m_hs = m_valid_o & m_ready_i;

  always_comb begin
    clr_mask      = '0;
    clr_mask[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      beat_data <= '0;
      rem_keep  <= '0;
      beat_last <= 1'b0;
    end else if (s_hs) begin
      // A new beat replaces whatever is left; s_hs with busy implies only the final lane remained.
      beat_data <= s_data_i;
      rem_keep  <= s_keep_i;
      beat_last <= s_last_i;
    end else if (m_hs) begin
      rem_keep <= rem_keep & ~clr_mask;
    end
  end

endmodule

// File: doc/stream_downsize.md
Name: stream_downsize

Overview:
Width-reducing stream converter: accepts one wide beat of T_DATA_RATIO lanes with per-lane keep and a last flag, and emits the kept lanes as narrow words, one per handshake. Lanes go out in ascending lane index order, and null lanes are skipped. The block sits on the transmit side of the datapath and inverts the lane packing done on the receive side. It holds one beat in a register and sustains one narrow word per cycle with no bubble between beats.

Parameters:
T_DATA_WIDTH, 1, width of one narrow word / one lane in bits
T_DATA_RATIO, 2, number of lanes per wide beat (>=2)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous reset, active-high: 1 = reset asserted (the port name keeps the codebase spelling)
s_data_i  in  T_DATA_WIDTH x [T_DATA_RATIO-1:0]  wide beat; lane 0 is sent first
s_keep_i  in  T_DATA_RATIO  per-lane valid mask; non-contiguous masks are legal
s_last_i  in  1  beat is the final beat of a packet
s_valid_i  in  1  wide beat valid
s_ready_o  out  1  wide beat accepted when s_valid_i && s_ready_o at clk edge
m_data_o  out  T_DATA_WIDTH  narrow word
m_last_o  out  1  final word of the packet
m_valid_o  out  1  narrow word valid
m_ready_i  in  1  downstream ready

Behaviour:
- State registers:
  - beat_data (R lanes)
  - rem_keep (R bits): lanes still to send
  - beat_last
- busy = |rem_keep.
- Reset (rst_n=1, async): rem_keep=0, beat_last=0, beat_data=0. While reset is asserted: m_valid_o=0, m_last_o=0, s_ready_o=0, m_data_o=0.
- Outputs (combinational from the registers only, except s_ready_o):
  - m_valid_o = busy
  - sel = index of lowest set bit of rem_keep
  - m_data_o = beat_data[sel]
  - m_last_o = beat_last && (rem_keep has exactly one bit set)
- s_ready_o = !busy || (m_ready_i && rem_keep one-hot). This is the only combinational in-to-out path (m_ready_i -> s_ready_o).
- Output handshake (m_valid_o && m_ready_i): clear bit sel of rem_keep.
- Input handshake: beat_data <= s_data_i, rem_keep <= s_keep_i, beat_last <= s_last_i. This overrides the bit-clear when both handshakes fall in the same cycle (final word of beat N and acceptance of beat N+1).
- Latency: a beat accepted at edge k presents its first kept word from cycle k+1.
- Throughput: a beat with n kept lanes occupies exactly n output cycles when m_ready_i=1, with no idle cycle between beats.
- m_valid_o low with m_ready_i high: no state change.
- m_valid_o high with m_ready_i low: m_data_o and m_last_o hold stable (AXI-style no-retract), and s_ready_o=0.
- All-zero s_keep_i: the beat is accepted and produces no words; rem_keep stays 0 so s_ready_o stays 1. If s_last_i=1 on that beat, the packet end is dropped. Upstream must not send an empty last beat; the bench flags this with an assertion.
- s_valid_i may be asserted or dropped at any time; there is no requirement on it.
- s_data_i on lanes with keep=0 is don't-care and never reaches m_data_o.
- Reset mid-beat: the remaining lanes are discarded. The first post-reset cycle has s_ready_o=1 and m_valid_o=0.

Decomposition:
- Package stream_pkg:
  - localparam/function for the lane index width: IDX_W = $clog2(T_DATA_RATIO), minimum 1.
  - function onehot(mask) returning whether mask has exactly one bit set.
- Sub-module lsb_find #(N): pure combinational lowest-set-bit priority encoder, outputs idx [IDX_W-1:0] and any. Used for sel and reusable by other stream blocks.
- Top level holds the beat register, the keep-clear logic and the handshakes.

Test Plan:
1. W=8, R=4, m_ready_i=1. Beat {0x44,0x33,0x22,0x11}, keep=4'b1111, last=1 -> m_data_o 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after accept. m_last_o=1 only on 0x44; s_ready_o=1 on the 0x44 cycle.
2. Back-to-back beats keep=1111 (last=0), then keep=0011 (last=1) -> 6 words with no gap. The second beat is accepted on the cycle the first beat's 4th word handshakes. m_last_o is set on the 6th word.
3. Sparse keep=4'b1010, data {0xDD,0xCC,0xBB,0xAA}, last=1 -> exactly 2 words, 0xBB then 0xDD (m_last_o=1). 0xAA and 0xCC never appear.
4. Backpressure: m_ready_i toggles randomly during a keep=1111 beat -> m_data_o and m_last_o stable while stalled, s_ready_o=0 until the final word handshakes. Word order and count are unchanged versus scenario 1.
5. Empty beat keep=0000, last=0, between two full beats -> no output word. The following beat is accepted on the next cycle.
6. Assert rst_n=1 asynchronously after 2 of 4 words -> m_valid_o=0 immediately. After release, s_ready_o=1 and a fresh beat outputs from lane 0.
